sipo_register: RTL and testbench
================================

# sipo_register

Serial-in, parallel-out shift register. It captures one serial bit per rising clock edge and presents the last WIDTH bits as a parallel word. It sits at the front of the serial-receive path and feeds downstream word-wide logic. An optional word-valid strobe marks each completed WIDTH-bit word.

## Interface
Parameters:
- WIDTH, default 4: parallel word width; legal range 2..64.
- SHIFT_LEFT, default 1: 1 = new bit enters the LSB and the word moves toward the MSB (first bit ends in the MSB); 0 = new bit enters the MSB and the word moves toward the LSB.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  synchronous, active-high clear. One clock; reset is synchronous and active-high.
- SI  input  1  serial data in; sampled every rising CLK edge while CLR=0.
- PO  output  WIDTH  parallel output; registered, equal to the internal shift register.
- VALID  output  1  word-complete strobe; present only with SIPO_WORD_VALID_EN.

## Operation
- On a rising edge with CLR=1:
  - PO <= 0.
  - Bit counter <= 0 and VALID <= 0 (when configured).
  - SI is ignored.
- On a rising edge with CLR=0, SHIFT_LEFT=1: PO <= {PO[WIDTH-2:0], SI}.
- On a rising edge with CLR=0, SHIFT_LEFT=0: PO <= {SI, PO[WIDTH-1:1]}.
- There is no enable. A bit is shifted on every non-clear edge.
- After WIDTH consecutive shifts, PO holds exactly the last WIDTH bits received. Older bits are discarded off the far end.
- CLR has priority over shifting on the same edge.
- PO is driven directly from flops. There is no combinational path from SI to PO.

## Timing
- Latency: SI sampled at edge n appears in the entry bit of PO immediately after edge n (1 cycle).
- A full word is available WIDTH edges after the first shifted bit.
- Clear is seen on PO immediately after the first rising edge with CLR=1. Asserting CLR mid-word clears PO and the counter, and the word in progress is lost.
- Deasserting CLR: the first edge with CLR=0 shifts SI in.
- Power-up: PO is undefined until the first clear edge. The bench must apply CLR before checking PO.
- SI must be stable around the rising edge. The bench changes SI between edges.

## Configuration
- Macro SIPO_WORD_VALID_EN.
- Defined:
  - Adds output VALID and a bit counter of width $clog2(WIDTH+1).
  - The counter increments on each shift edge.
  - On the edge that shifts the WIDTH-th bit since clear or since the last word, the counter wraps to 0 and VALID goes high for exactly one cycle, coincident with the completed PO.
  - Continuous streaming produces one VALID pulse every WIDTH cycles.
  - VALID resets to 0.
- Undefined:
  - No VALID port and no counter.
  - Behaviour of PO is identical in both builds.

## Structure
- Shared package sipo_pkg:
  - SIPO_DEFAULT_WIDTH = 4.
  - Direction constants SIPO_DIR_LEFT = 1 and SIPO_DIR_RIGHT = 0.
  - Typedef for the counter width helper.
- One sub-module, sipo_bit_counter:
  - Modulo-WIDTH counter with a synchronous clear and a wrap strobe.
  - Instantiated only under SIPO_WORD_VALID_EN.
- The shift register itself stays in the top level.

## Test plan
- Clear then pattern (WIDTH=4, SHIFT_LEFT=1): CLR=1 for one edge, then SI 1,1,0,1 on four edges -> PO 0000, 0001, 0011, 0110, 1101.
- Clear mid-word: shift 1,1, then assert CLR for one edge -> PO=0000. Then shift 1 -> PO=0001. Counter restarts, so VALID fires 4 shifts later, not 2.
- Overflow: from 1101, shift 0,0 -> PO 1010, 0100. Oldest bits are dropped.
- Right shift (SHIFT_LEFT=0, WIDTH=4): after clear, SI 1,1,0,1 -> PO 1000, 1100, 0110, 1011.
- VALID (macro defined): after clear, stream 8 bits 10110010 -> VALID high only after edges 4 and 8, with PO=1011 and PO=0010 respectively.
- Clear priority: CLR=1 with SI=1 on the same edge -> PO=0000, and VALID=0 when configured.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out receive front end.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;
    localparam int SIPO_DIR_LEFT      = 1;
    localparam int SIPO_DIR_RIGHT     = 0;

    // Widest counter needed for the largest legal word (64 bits).
    localparam int SIPO_MAX_CNT_W = 7;
    typedef logic [SIPO_MAX_CNT_W-1:0] sipo_cnt_t;

    function automatic int sipo_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; wrap_o is a registered strobe raised on the edge
// that counts the WIDTH-th increment.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic srst,
    input  logic inc,
    output logic wrap
);
    localparam int CNT_W = sipo_cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap_reg;
    logic             wrap_next;

    always_comb begin
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (inc) begin
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            wrap_reg <= wrap_next;
        end
    end

    assign wrap = wrap_reg;

endmodule

// File: rtl/sipo_register.sv
// Serial-in, parallel-out shift register. Define SIPO_WORD_VALID_EN to add the
// VALID strobe that marks each completed WIDTH-bit word.
module sipo_register
    import sipo_pkg::*;
#(
    parameter int WIDTH      = SIPO_DEFAULT_WIDTH,
    parameter int SHIFT_LEFT = SIPO_DIR_LEFT
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SI,
    output logic [WIDTH-1:0] PO
`ifdef SIPO_WORD_VALID_EN
    ,
    output logic             VALID
`endif
);
    logic [WIDTH-1:0] po_reg;
    logic [WIDTH-1:0] po_next;

    // Each bit takes its neighbour towards the entry end; the entry bit takes SI.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (SHIFT_LEFT != SIPO_DIR_RIGHT) begin : g_left
                if (gi == 0) begin : g_entry
                    assign po_next[gi] = SI;
                end else begin : g_move
                    assign po_next[gi] = po_reg[gi-1];
                end
            end else begin : g_right
                if (gi == WIDTH - 1) begin : g_entry
                    assign po_next[gi] = SI;
                end else begin : g_move
                    assign po_next[gi] = po_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (CLR) begin
            po_reg <= '0;
        end else begin
            po_reg <= po_next;
        end
    end

    assign PO = po_reg;

`ifdef SIPO_WORD_VALID_EN
    // Every non-clear edge is a shift, so the counter increments unconditionally.
    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk  (CLK),
        .srst (CLR),
        .inc  (1'b1),
        .wrap (VALID)
    );
`endif

endmodule

// File: tb/tb_sipo_register.sv
// Bench for sipo_register: directed test-plan sequences plus random streams,
// checked against a history-of-bits reference model.
module tb_sipo_register;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       si  = 1'b0;
    logic [3:0] po_l4;
    logic [3:0] po_r4;
    logic [6:0] po_l7;
`ifdef SIPO_WORD_VALID_EN
    logic       valid_l4;
    logic       valid_r4;
    logic       valid_l7;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Bits received since the last clear, oldest first.
    bit hist[$];

    always #5 clk = ~clk;

    sipo_register #(.WIDTH(4), .SHIFT_LEFT(1)) u_l4 (
        .CLK(clk), .CLR(clr), .SI(si), .PO(po_l4)
`ifdef SIPO_WORD_VALID_EN
        , .VALID(valid_l4)
`endif
    );

    sipo_register #(.WIDTH(4), .SHIFT_LEFT(0)) u_r4 (
        .CLK(clk), .CLR(clr), .SI(si), .PO(po_r4)
`ifdef SIPO_WORD_VALID_EN
        , .VALID(valid_r4)
`endif
    );

    sipo_register #(.WIDTH(7), .SHIFT_LEFT(1)) u_l7 (
        .CLK(clk), .CLR(clr), .SI(si), .PO(po_l7)
`ifdef SIPO_WORD_VALID_EN
        , .VALID(valid_l7)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Newest bit sits at the entry end; missing history reads as zero.
    function automatic logic [63:0] model_po(input int width, input bit left);
        logic [63:0] r;
        int          n;
        r = '0;
        n = hist.size();
        for (int i = 0; i < width; i++) begin
            if (i < n) begin
                if (left) r[i] = hist[n-1-i];
                else      r[width-1-i] = hist[n-1-i];
            end
        end
        return r;
    endfunction

    function automatic logic model_valid(input int width);
        return (hist.size() > 0) && (hist.size() % width == 0);
    endfunction

    task automatic step(input bit c, input bit s);
        @(negedge clk);
        clr = c;
        si  = s;
        @(posedge clk);
        if (c) hist.delete();
        else   hist.push_back(s);
        #1;
        check("po_l4", 64'(po_l4), model_po(4, 1'b1));
        check("po_r4", 64'(po_r4), model_po(4, 1'b0));
        check("po_l7", 64'(po_l7), model_po(7, 1'b1));
`ifdef SIPO_WORD_VALID_EN
        check("valid_l4", 64'(valid_l4), 64'(model_valid(4)));
        check("valid_r4", 64'(valid_r4), 64'(model_valid(4)));
        check("valid_l7", 64'(valid_l7), 64'(model_valid(7)));
`endif
        $display("step clr=%0b si=%0b po_l4=%b po_r4=%b po_l7=%b", c, s, po_l4, po_r4, po_l7);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Clear, then 1,1,0,1 with the far-end overflow that follows.
        step(1'b1, 1'b1);
        check("reset_l4", 64'(po_l4), 64'h0);
        check("reset_r4", 64'(po_r4), 64'h0);
        shift_bits(32'b1101, 4);
        check("pattern_l4", 64'(po_l4), 64'b1101);
        check("pattern_r4", 64'(po_r4), 64'b1011);
        shift_bits(32'b00, 2);
        check("overflow_l4", 64'(po_l4), 64'b0100);

        // Mid-word clear drops the partial word and restarts the count.
        step(1'b1, 1'b0);
        shift_bits(32'b11, 2);
        step(1'b1, 1'b1);
        check("midclr_l4", 64'(po_l4), 64'h0);
        shift_bits(32'b1, 1);
        check("after_midclr_l4", 64'(po_l4), 64'b0001);
        shift_bits(32'b010, 3);

        // Two full words back to back.
        step(1'b1, 1'b0);
        shift_bits(32'b10110010, 8);
        check("stream_l4", 64'(po_l4), 64'b0010);
        check("stream_l7", 64'(po_l7), 64'b0110010);

        // Random stream with occasional clears, including clear with SI=1.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
